// File: rtl/store_unit_pkg.sv
// Shared types for the store path: size codes, memory op codes, FSM states and size decode.
package store_unit_pkg;

    typedef enum logic [2:0] {
        NOP           = 3'd0,
        BYTE_SIGNED   = 3'd1,
        BYTE_UNSIGNED = 3'd2,
        HALF_SIGNED   = 3'd3,
        HALF_UNSIGNED = 3'd4,
        WORD          = 3'd5,
        DWORD         = 3'd6
    } mem_sel_e;

    typedef enum logic [1:0] {
        MEM_OP_NONE  = 2'd0,
        MEM_OP_LOAD  = 2'd1,
        MEM_OP_STORE = 2'd2
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam int SIZE_W = 4;

    // Returns the store size in bytes, or 0 for a code that is illegal on this bus width.
    function automatic logic [SIZE_W-1:0] sel_bytes(input mem_sel_e sel, input logic dword_ok);
        case (sel)
            BYTE_SIGNED, BYTE_UNSIGNED: return 4'd1;
            HALF_SIGNED, HALF_UNSIGNED: return 4'd2;
            WORD:                       return 4'd4;
            DWORD:                      return dword_ok ? 4'd8 : 4'd0;
            default:                    return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/store_unit_lane_align.sv
// Combinational lane steering: turns (offset, size, data) into strobes and data for up to two beats.
module store_lane_align
    import store_unit_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int OFF_W  = $clog2(NB)
) (
    input  logic [OFF_W-1:0]  off,
    input  logic [SIZE_W-1:0] size,
    input  logic [DATA_W-1:0] data,
    output logic [NB-1:0]     wstrb0,
    output logic [NB-1:0]     wstrb1,
    output logic [DATA_W-1:0] wdata0,
    output logic [DATA_W-1:0] wdata1,
    output logic              split
);

    logic [2*NB-1:0]     mask;
    logic [2*NB-1:0]     mask_sh;
    logic [2*DATA_W-1:0] data_sh;

    // NOTE: every signal written here is fully assigned on every pass, so no latch can be inferred.
    always_comb begin
        mask = '0;
        for (int i = 0; i < 2 * NB; i++) begin
            mask[i] = (i < int'(size));
        end
        mask_sh = mask << off;
        data_sh = {{DATA_W{1'b0}}, data} << {off, 3'b000};
        wstrb0  = mask_sh[NB-1:0];
        wstrb1  = mask_sh[2*NB-1:NB];
        wdata0  = data_sh[DATA_W-1:0];
        wdata1  = data_sh[2*DATA_W-1:DATA_W];
        split   = |mask_sh[2*NB-1:NB];
    end

endmodule

// File: rtl/store_unit.sv
// Store path from execute to the data bus: aligns, strobes and optionally splits one store per handshake.
module store_unit
    import store_unit_pkg::*;
#(
    parameter  int ADDR_W           = 32,
    parameter  int DATA_W           = 32,
    parameter  bit ALLOW_MISALIGNED = 1'b1,
    localparam int NB               = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [2:0]        req_sel,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [NB-1:0]     bus_wstrb,
    output logic              done,
    output logic              fault,
    output logic              busy
);

    localparam int OFF_W = $clog2(NB);

    state_e            state_q, state_d;
    logic              bus_valid_q, bus_valid_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [NB-1:0]     bus_wstrb_q, bus_wstrb_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic              split_q, split_d;
    logic [DATA_W-1:0] wdata1_q, wdata1_d;
    logic [NB-1:0]     wstrb1_q, wstrb1_d;

    logic [OFF_W-1:0]  off;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] base_addr;
    logic [NB-1:0]     strb0, strb1;
    logic [DATA_W-1:0] data0, data1;
    logic              split;
    logic              reject;

    assign off       = req_addr[OFF_W-1:0];
    assign size      = sel_bytes(mem_sel_e'(req_sel), DATA_W == 64);
    assign base_addr = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign reject    = (size == '0) || (split && !ALLOW_MISALIGNED);

    store_lane_align #(.DATA_W(DATA_W)) u_align (
        .off    (off),
        .size   (size),
        .data   (req_data),
        .wstrb0 (strb0),
        .wstrb1 (strb1),
        .wdata0 (data0),
        .wdata1 (data1),
        .split  (split)
    );

    always_comb begin
        state_d     = state_q;
        bus_valid_d = bus_valid_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        split_d     = split_q;
        wdata1_d    = wdata1_q;
        wstrb1_d    = wstrb1_q;
        done_d      = 1'b0;
        fault_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (reject) begin
                        state_d = ST_RESP;
                        fault_d = 1'b1;
                    end else begin
                        // Beat 0 goes out registered; beat 1 is parked until beat 0 is taken.
                        state_d     = ST_BEAT0;
                        bus_valid_d = 1'b1;
                        bus_addr_d  = base_addr;
                        bus_wdata_d = data0;
                        bus_wstrb_d = strb0;
                        split_d     = split;
                        wdata1_d    = data1;
                        wstrb1_d    = strb1;
                    end
                end
            end
            ST_BEAT0: begin
                if (bus_ready) begin
                    if (split_q) begin
                        state_d     = ST_BEAT1;
                        bus_addr_d  = bus_addr_q + ADDR_W'(NB);
                        bus_wdata_d = wdata1_q;
                        bus_wstrb_d = wstrb1_q;
                    end else begin
                        state_d     = ST_RESP;
                        bus_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            ST_BEAT1: begin
                if (bus_ready) begin
                    state_d     = ST_RESP;
                    bus_valid_d = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bus_valid_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            split_q     <= 1'b0;
            wdata1_q    <= '0;
            wstrb1_q    <= '0;
        end else begin
            state_q     <= state_d;
            bus_valid_q <= bus_valid_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            split_q     <= split_d;
            wdata1_q    <= wdata1_d;
            wstrb1_q    <= wstrb1_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign bus_valid = bus_valid_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;
    assign done      = done_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit on a 32-bit bus, with a second instance that faults misaligned stores.
module tb_store_unit;
    import store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_valid_b = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [2:0]  req_sel = '0;
    logic        bus_ready = 1'b1;

    logic        req_ready, bus_valid, done, fault, busy;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        req_ready_b, bus_valid_b, done_b, fault_b, busy_b;
    logic [31:0] bus_addr_b, bus_wdata_b;
    logic [3:0]  bus_wstrb_b;

    int checks = 0;
    int errors = 0;

    store_unit #(.ADDR_W(32), .DATA_W(32), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_sel(req_sel),
        .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .done(done), .fault(fault), .busy(busy)
    );

    store_unit #(.ADDR_W(32), .DATA_W(32), .ALLOW_MISALIGNED(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_addr(req_addr), .req_data(req_data), .req_sel(req_sel),
        .bus_valid(bus_valid_b), .bus_ready(bus_ready),
        .bus_addr(bus_addr_b), .bus_wdata(bus_wdata_b), .bus_wstrb(bus_wstrb_b),
        .done(done_b), .fault(fault_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request for exactly one rising edge, then scrambles the request inputs.
    task automatic accept(input logic to_b, input logic [31:0] addr, input logic [31:0] data,
                          input mem_sel_e sel);
        @(negedge clk);
        req_addr = addr;
        req_data = data;
        req_sel  = sel;
        if (to_b) begin
            req_valid_b = 1'b1;
            check("accept_ready_b", {63'd0, req_ready_b}, 64'd1);
        end else begin
            req_valid = 1'b1;
            check("accept_ready", {63'd0, req_ready}, 64'd1);
        end
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        req_valid_b = 1'b0;
        req_addr    = 32'h5555_5555;
        req_data    = 32'hA5A5_A5A5;
        req_sel     = 3'd5;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_bus_valid", {63'd0, bus_valid}, 64'd0);
        check("rst_bus_addr", {32'd0, bus_addr}, 64'd0);
        check("rst_bus_wdata", {32'd0, bus_wdata}, 64'd0);
        check("rst_bus_wstrb", {60'd0, bus_wstrb}, 64'd0);
        check("rst_done_fault_busy", {61'd0, done, fault, busy}, 64'd0);
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        rst = 1'b0;

        // Aligned word: one beat, done two edges after accept
        accept(1'b0, 32'h0000_1000, 32'hDEAD_BEEF, WORD);
        @(negedge clk);
        check("w_valid", {63'd0, bus_valid}, 64'd1);
        check("w_addr", {32'd0, bus_addr}, 64'h1000);
        check("w_wstrb", {60'd0, bus_wstrb}, 64'hF);
        check("w_wdata", {32'd0, bus_wdata}, 64'hDEAD_BEEF);
        check("w_busy_ready_done", {61'd0, busy, req_ready, done}, 64'b100);
        @(negedge clk);
        check("w_done", {62'd0, done, bus_valid}, 64'b10);
        @(negedge clk);
        check("w_idle", {61'd0, done, req_ready, busy}, 64'b010);

        // Byte at offset 3
        accept(1'b0, 32'h0000_1003, 32'h0000_00AB, BYTE_UNSIGNED);
        @(negedge clk);
        check("b_addr", {32'd0, bus_addr}, 64'h1000);
        check("b_wstrb", {60'd0, bus_wstrb}, 64'b1000);
        check("b_wdata", {32'd0, bus_wdata}, 64'hAB00_0000);
        @(negedge clk);
        check("b_done", {63'd0, done}, 64'd1);

        // Half crossing the word boundary: split into two beats
        accept(1'b0, 32'h0000_1003, 32'h0000_1234, HALF_UNSIGNED);
        @(negedge clk);
        check("h0_beat", {bus_valid, 27'd0, bus_wstrb, bus_addr}, {1'b1, 27'd0, 4'b1000, 32'h1000});
        check("h0_wdata", {32'd0, bus_wdata}, 64'h3400_0000);
        @(negedge clk);
        check("h1_beat", {bus_valid, 27'd0, bus_wstrb, bus_addr}, {1'b1, 27'd0, 4'b0001, 32'h1004});
        check("h1_wdata", {32'd0, bus_wdata}, 64'h0000_0012);
        check("h1_no_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        check("h_done", {62'd0, done, bus_valid}, 64'b10);

        // Same half on the instance that faults misaligned stores
        accept(1'b1, 32'h0000_1003, 32'h0000_1234, HALF_UNSIGNED);
        @(negedge clk);
        check("m0_fault", {61'd0, fault_b, done_b, bus_valid_b}, 64'b100);
        @(negedge clk);
        check("m0_after", {61'd0, fault_b, bus_valid_b, req_ready_b}, 64'b001);

        // Aligned word still works on the faulting instance
        accept(1'b1, 32'h0000_2000, 32'h0102_0304, WORD);
        @(negedge clk);
        check("m0_word", {bus_valid_b, 27'd0, bus_wstrb_b, bus_addr_b}, {1'b1, 27'd0, 4'hF, 32'h2000});
        @(negedge clk);
        check("m0_word_done", {62'd0, done_b, fault_b}, 64'b10);

        // Word split across the top of the address space
        accept(1'b0, 32'hFFFF_FFFE, 32'hCAFE_F00D, WORD);
        @(negedge clk);
        check("wrap0_beat", {28'd0, bus_wstrb, bus_addr}, {28'd0, 4'b1100, 32'hFFFF_FFFC});
        check("wrap0_wdata", {32'd0, bus_wdata}, 64'hF00D_0000);
        @(negedge clk);
        check("wrap1_beat", {28'd0, bus_wstrb, bus_addr}, {28'd0, 4'b0011, 32'h0000_0000});
        check("wrap1_wdata", {32'd0, bus_wdata}, 64'h0000_CAFE);
        @(negedge clk);
        check("wrap_done", {63'd0, done}, 64'd1);

        // Illegal size codes fault without bus traffic
        accept(1'b0, 32'h0000_1000, 32'h1111_1111, NOP);
        @(negedge clk);
        check("nop_fault", {61'd0, fault, done, bus_valid}, 64'b100);
        @(negedge clk);
        check("nop_clear", {62'd0, fault, bus_valid}, 64'b00);
        accept(1'b0, 32'h0000_1000, 32'h2222_2222, DWORD);
        @(negedge clk);
        check("dword_fault", {61'd0, fault, done, bus_valid}, 64'b100);

        // Bus stall in BEAT0: outputs stay put for three cycles
        bus_ready = 1'b0;
        accept(1'b0, 32'h0000_3004, 32'h0BAD_F00D, WORD);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_beat", {bus_valid, req_ready, done, 25'd0, bus_wstrb, bus_addr},
                  {1'b1, 1'b0, 1'b0, 25'd0, 4'hF, 32'h3004});
            check("stall_wdata", {32'd0, bus_wdata}, 64'h0BAD_F00D);
        end
        bus_ready = 1'b1;
        @(negedge clk);
        check("stall_done", {62'd0, done, bus_valid}, 64'b10);
        @(negedge clk);
        check("stall_single_done", {63'd0, done}, 64'd0);

        // Reset during BEAT1 abandons the store
        accept(1'b0, 32'h0000_1003, 32'h0000_1234, HALF_UNSIGNED);
        @(negedge clk);
        @(negedge clk);
        check("rb1_in_beat1", {bus_valid, 31'd0, bus_addr}, {1'b1, 31'd0, 32'h1004});
        rst = 1'b1;
        #1;
        check("rb1_async_drop", {61'd0, bus_valid, done, fault}, 64'b000);
        @(negedge clk);
        rst = 1'b0;
        check("rb1_held", {60'd0, req_ready, busy, done, fault}, 64'b1000);
        @(negedge clk);
        check("rb1_no_pulse", {61'd0, done, fault, bus_valid}, 64'b000);

        accept(1'b0, 32'h0000_4000, 32'h1234_5678, WORD);
        @(negedge clk);
        check("post_rst_beat", {bus_valid, 27'd0, bus_wstrb, bus_addr}, {1'b1, 27'd0, 4'hF, 32'h4000});
        check("post_rst_wdata", {32'd0, bus_wdata}, 64'h1234_5678);
        @(negedge clk);
        check("post_rst_done", {62'd0, done, fault}, 64'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
Sequential store path that sits between the S-type decode/execute stage and the data-memory bus. It accepts one store request per handshake: the byte address comes from the ALU ADD result, and the data and size come from rs2 and mem_sel. It drives an aligned bus write with byte strobes and lane-shifted data. This is the parametrised successor to the fixed 32-bit store decode: bus width is configurable, misaligned stores are split into two beats (or faulted, per parameter), and both sides use valid/ready handshakes.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, bus/data width in bits; legal values 32 or 64
NB, DATA_W/8, bytes per beat (derived localparam, not overridable)
ALLOW_MISALIGNED, 1, 1 = split a line-crossing store into two beats; 0 = raise fault with no bus traffic

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  store request valid
req_ready  out  1  unit can accept a request; high only in IDLE
req_addr  in  ADDR_W  byte address
req_data  in  DATA_W  store data, LSB-justified
req_sel  in  3  size code from MEM_SEL_ENUM
bus_valid  out  1  bus write valid
bus_ready  in  1  bus accepts the current beat
bus_addr  out  ADDR_W  NB-aligned beat address
bus_wdata  out  DATA_W  lane-shifted write data
bus_wstrb  out  NB  byte strobes
done  out  1  one-cycle pulse: store fully written
fault  out  1  one-cycle pulse: store rejected
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE; bus_valid=0, bus_addr=0, bus_wdata=0, bus_wstrb=0, done=0, fault=0, busy=0, req_ready=1.
  - Reset asserted mid-operation drops bus_valid immediately and abandons the store. No done or fault is produced.
- Size decode:
  - BYTE_SIGNED/BYTE_UNSIGNED = 1 byte; HALF_SIGNED/HALF_UNSIGNED = 2; WORD = 4; DWORD = 8 (legal only when DATA_W=64).
  - NOP or any other code is illegal.
- Offset and strobes:
  - off = req_addr[log2(NB)-1:0]; mask = (1<<size)-1, width 2*NB.
  - Beat0: addr = req_addr with low bits cleared; wstrb = (mask<<off)[NB-1:0]; wdata = (req_data<<8*off)[DATA_W-1:0].
  - Beat1: addr = beat0 addr + NB, wrapping modulo 2^ADDR_W; wstrb = (mask<<off)[2NB-1:NB]; wdata = req_data>>(8*(NB-off)).
- FSM states: IDLE, BEAT0, BEAT1, RESP.
  - IDLE:
    - On req_valid&&req_ready, latch the request.
    - Illegal size, or off+size>NB with ALLOW_MISALIGNED=0 -> RESP with fault.
    - Otherwise -> BEAT0 with bus outputs registered the same edge, so bus_valid is high the next cycle.
  - BEAT0: hold bus_valid and all bus outputs stable until bus_ready. On handshake: split -> BEAT1 (outputs reloaded the same edge); else -> RESP.
  - BEAT1: hold until bus_ready; on handshake -> RESP.
  - RESP: done (or fault) high for exactly one cycle, bus_valid=0 -> IDLE.
- Latency: accept at edge N; bus_valid at N+1; with bus_ready=1, done at N+2 (single beat) or N+3 (split). A fault pulse arrives at N+1.
- No new request is accepted while busy. Back-to-back requests: next accept no earlier than the RESP cycle + 1.
- bus_valid must never deassert without a handshake, except on reset.
- Changes to req_* after acceptance are ignored.

Decomposition:
- Shared package: MEM_SEL_ENUM (add DWORD code), MEM_OP_ENUM reused, and FSM state localparams.
- Sub-module store_lane_align (combinational): in = addr offset, size, data; out = beat0/beat1 wstrb and wdata, plus a split flag. It is instantiated once in store_unit.

Test Plan:
- DATA_W=32, WORD, addr 0x1000, data 0xDEADBEEF, bus_ready=1 -> one beat: addr 0x1000, wstrb 1111, wdata 0xDEADBEEF; done at accept+2.
- BYTE, addr 0x1003, data 0x000000AB -> addr 0x1000, wstrb 1000, wdata 0xAB000000; done.
- HALF, addr 0x1003, data 0x1234, ALLOW_MISALIGNED=1 -> beat0: 0x1000/1000/0x34000000; beat1: 0x1004/0001/0x00000012; done at accept+3. Same stimulus with ALLOW_MISALIGNED=0 -> fault at accept+1, bus_valid never high.
- WORD, addr 0xFFFFFFFE, split -> beat1 addr 0x00000000 (wrap), wstrb 0011; sel=NOP -> fault, no bus traffic.
- bus_ready held low 3 cycles during BEAT0 -> bus_addr, bus_wdata, bus_wstrb stable and bus_valid high throughout; req_ready low; one done after release.
- rst asserted during BEAT1 -> bus_valid=0 in the same cycle, no done/fault; after release req_ready=1 and the next WORD store completes normally.
